sd_sector_stream: RTL

- Multi-sector streaming front end for the SPI sector reader.
- Takes a (first sector, count) request and issues one sector read at a time on the reader's start/sector_no/done interface.
- Captures each 512-byte burst (rvalid/raddr/rdata, no backpressure) into a two-bank ping-pong buffer, and replays the bytes as a valid/ready byte stream.
- Read-ahead: at most one sector in flight while the other bank drains.

---
 rtl/sd_stream_pkg.sv | 18 +
 rtl/sd_pingpong_ram.sv | 25 ++
 rtl/sd_sector_stream.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sd_stream_pkg.sv
// sd_stream_pkg: shared types and constants for the
// multi-sector SPI read streaming front end.
package sd_stream_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_ISSUE = 3'd1;
    localparam state_t S_RECV  = 3'd2;
    localparam state_t S_HOLD  = 3'd3;
    localparam state_t S_DRAIN = 3'd4;
    localparam state_t S_ERR   = 3'd5;

    localparam int SECTOR_BYTES = 512;

    typedef logic bank_t;

endpackage

// File: rtl/sd_pingpong_ram.sv
// sd_pingpong_ram: 1024x8 simple dual-port RAM, two 512-byte
// banks addressed as {bank, byte}, registered read.
module sd_pingpong_ram
    import sd_stream_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [9:0] waddr,
    input  logic [7:0] wdata,
    input  logic       re,
    input  logic [9:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [1024];

    // write port plus read port whose output holds when not enabled
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/sd_sector_stream.sv
// sd_sector_stream: issues sector reads one at a time, captures each
// 512-byte burst into a ping-pong buffer and replays it as a stream.
module sd_sector_stream
    import sd_stream_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_start,
    input  logic [31:0] req_first_sector,
    input  logic [15:0] req_count,
    output logic        busy,
    output logic        finished,
    output logic        err,
    output logic        rd_start,
    output logic [31:0] rd_sector_no,
    input  logic        rd_done,
    input  logic        rd_rvalid,
    input  logic [8:0]  rd_raddr,
    input  logic [7:0]  rd_rdata,
    output logic        m_valid,
    output logic [7:0]  m_data,
    output logic        m_last,
    input  logic        m_ready
);

    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic [31:0] sector;
    logic [15:0] remaining;
    logic [15:0] f_rem;
    logic [9:0]  bcnt, bcnt_n;
    logic [23:0] tcnt;
    logic [1:0]  full, full_n;
    bank_t       wr_bank, rd_bank, f_bank;
    logic [8:0]  f_idx;
    logic        p_valid, p_eob, p_last, m_eob;
    logic [7:0]  ram_q;
    logic        accept_req, wr_en, sec_ok, go_err, timeout;
    logic        out_free, mv, fetch, accept, free_ev;

    assign accept_req   = req_start && !busy && (state == S_IDLE);
    assign wr_en        = rd_rvalid && (state == S_ISSUE || state == S_RECV);
    assign bcnt_n       = bcnt + 10'(wr_en);
    assign timeout      = (tcnt == TMO_LAST);
    assign sec_ok       = (state == S_RECV) && rd_done && (bcnt_n == 10'(SECTOR_BYTES));
    assign accept       = m_valid && m_ready;
    assign out_free     = !m_valid || m_ready;
    assign mv           = p_valid && out_free;
    assign fetch        = full[f_bank] && (!p_valid || mv);
    assign free_ev      = accept && m_eob;
    assign rd_start     = (state == S_ISSUE);
    assign rd_sector_no = sector;

    sd_pingpong_ram u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wr_bank, rd_raddr}),
        .wdata (rd_rdata),
        .re    (fetch),
        .raddr ({f_bank, f_idx}),
        .rdata (ram_q)
    );

    // bank full flags after this cycle's fill and drain events
    always_comb begin
        full_n = full;
        if (free_ev)
            full_n[rd_bank] = 1'b0;
        if (sec_ok)
            full_n[wr_bank] = 1'b1;
    end

    // request sequencing: issue, receive, wait for a free bank, drain
    always_comb begin
        state_n = state;
        go_err  = 1'b0;
        unique case (state)
            S_IDLE:
                if (accept_req && req_count != 16'd0)
                    state_n = S_ISSUE;
            S_ISSUE:
                if (rd_done || timeout)
                    go_err = 1'b1;
                else if (rd_rvalid)
                    state_n = S_RECV;
            S_RECV:
                if (rd_done) begin
                    if (!sec_ok)
                        go_err = 1'b1;
                    else if (remaining == 16'd1)
                        state_n = S_DRAIN;
                    else if (full_n[~wr_bank])
                        state_n = S_HOLD;
                    else
                        state_n = S_ISSUE;
                end else if (timeout) begin
                    go_err = 1'b1;
                end
            S_HOLD:
                if (!full[wr_bank])
                    state_n = S_ISSUE;
            S_DRAIN:
                if (full == 2'b00)
                    state_n = S_IDLE;
            S_ERR:
                state_n = S_IDLE;
            default:
                state_n = S_IDLE;
        endcase
        if (go_err)
            state_n = S_ERR;
    end

    // control state, request bookkeeping, byte and timeout counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            finished  <= 1'b0;
            err       <= 1'b0;
            sector    <= 32'd0;
            remaining <= 16'd0;
            bcnt      <= 10'd0;
            tcnt      <= 24'd0;
        end else begin
            state    <= state_n;
            finished <= 1'b0;
            if (accept_req) begin
                sector    <= req_first_sector;
                remaining <= req_count;
                err       <= 1'b0;
                busy      <= 1'b1;
                finished  <= (req_count == 16'd0);
            end else if (state == S_IDLE) begin
                busy <= 1'b0;
            end
            if (go_err)
                err <= 1'b1;
            if (state == S_ERR || (state == S_DRAIN && state_n == S_IDLE)) begin
                finished <= 1'b1;
                busy     <= 1'b0;
            end
            if (state_n == S_ISSUE && state != S_ISSUE) begin
                bcnt <= 10'd0;
                tcnt <= 24'd0;
            end else begin
                bcnt <= bcnt_n;
                if (state == S_ISSUE || state == S_RECV)
                    tcnt <= tcnt + 24'd1;
            end
            if (sec_ok) begin
                sector    <= sector + 32'd1;
                remaining <= remaining - 16'd1;
            end
        end
    end

    // bank pointers, prefetch stage and stream output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            f_bank  <= 1'b0;
            f_idx   <= 9'd0;
            f_rem   <= 16'd0;
            p_valid <= 1'b0;
            p_eob   <= 1'b0;
            p_last  <= 1'b0;
            m_valid <= 1'b0;
            m_eob   <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= 8'd0;
        end else if (go_err || accept_req) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            f_bank  <= 1'b0;
            f_idx   <= 9'd0;
            f_rem   <= accept_req ? req_count : 16'd0;
            p_valid <= 1'b0;
            p_eob   <= 1'b0;
            p_last  <= 1'b0;
            m_valid <= 1'b0;
            m_eob   <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            full <= full_n;
            if (sec_ok)
                wr_bank <= ~wr_bank;
            if (free_ev)
                rd_bank <= ~rd_bank;
            if (fetch) begin
                f_idx   <= f_idx + 9'd1;
                p_eob   <= (f_idx == 9'd511);
                p_last  <= (f_idx == 9'd511) && (f_rem == 16'd1);
                p_valid <= 1'b1;
                if (f_idx == 9'd511) begin
                    f_bank <= ~f_bank;
                    f_rem  <= f_rem - 16'd1;
                end
            end else if (mv) begin
                p_valid <= 1'b0;
            end
            if (mv) begin
                m_valid <= 1'b1;
                m_data  <= ram_q;
                m_eob   <= p_eob;
                m_last  <= p_last;
            end else if (accept) begin
                m_valid <= 1'b0;
                m_eob   <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end

endmodule
